// File: rtl/aes_cipher_iterative_if.sv
// ---------------------------------------------------------------------------
// aes_cipher_iterative_if
// Handshake bundle between the block source, the iterative AES encryptor and
// the ciphertext sink.
//   in_valid / in_ready   : plaintext + key offered / block can be accepted
//   plaintext [127:0]     : [127:120] = byte 0 (s0,0), column-major
//   key [Nk*32-1:0]       : cipher key, [Nk*32-1 -: 32] = w0
//   out_valid / out_ready : ciphertext offered / sink accepts it
//   ciphertext [127:0]    : result, same byte order as plaintext
//   busy                  : encryptor is running rounds
// master = source/sink side, slave = encryptor side.
// ---------------------------------------------------------------------------
interface aes_cipher_iterative_if #(
   parameter int Nk = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [127:0]      plaintext;
   logic [Nk*32-1:0]  key;
   logic              out_valid;
   logic              out_ready;
   logic [127:0]      ciphertext;
   logic              busy;

   modport master (
      output in_valid, plaintext, key, out_ready,
      input  in_ready, out_valid, ciphertext, busy
   );

   modport slave (
      input  in_valid, plaintext, key, out_ready,
      output in_ready, out_valid, ciphertext, busy
   );
endinterface

// File: rtl/aes_cipher_iterative.sv
// ---------------------------------------------------------------------------
// aes_cipher_iterative
// FIPS-197 forward cipher, one round per clock on a single 128-bit state
// register. Round 0 (AddRoundKey with w0..w3) is folded into the accept edge,
// so the ciphertext is registered Nr edges after the accept.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : aes_cipher_iterative_if.slave (in/out handshakes, data, busy)
// Parameter Nk = 4/6/8 selects AES-128/192/256; Nr = Nk+6 is derived.
// ---------------------------------------------------------------------------
module aes_cipher_iterative #(
   parameter int Nk = 4
) (
   input logic                    clk,
   input logic                    reset,
   aes_cipher_iterative_if.slave  bus
);
   localparam int          Nr  = Nk + 6;
   localparam int          KW  = Nk * 32;
   localparam int          NW  = 4 * (Nr + 1);
   localparam logic [3:0]  NR4 = 4'(Nr);

   if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_illegal_nk
      $error("aes_cipher_iterative: Nk must be 4, 6 or 8");
   end

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

   // ---------------- GF(2^8) helpers and round primitives ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box built from its definition: inverse (x^254, which maps 0 to 0)
   // followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         inv = gf_mul(inv, inv);
         if (i != 0) inv = gf_mul(inv, x);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Full KeyExpansion from the latched key, returning words w[4r..4r+3].
   function automatic logic [127:0] round_key(input logic [KW-1:0] k, input logic [3:0] r);
      logic [31:0] w [NW];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < Nk; i++) w[i] = k[KW-1-32*i -: 32];
      for (int i = Nk; i < NW; i++) begin
         t = w[i-1];
         if (i % Nk == 0) begin
            t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = xtime(rcon);
         end else if (Nk > 6 && i % Nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-Nk] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // SubBytes -> ShiftRows -> MixColumns (skipped when last) -> AddRoundKey.
   // Byte n of the state is s[n%4][n/4].
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      o = '0;
      for (int n = 0; n < 16; n++) b[n] = sbox(s[127-8*n -: 8]);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
         a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
         if (last) begin
            o[127-32*c -: 32] = {a0, a1, a2, a3};
         end else begin
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
         end
      end
      return o ^ rk;
   endfunction

   // ---------------- state ----------------
   state_e            state_q, state_d;
   logic [3:0]        round_q, round_d;
   logic [127:0]      data_q, data_d;
   logic [KW-1:0]     key_q, key_d;
   logic [127:0]      ct_q, ct_d;
   logic              out_valid_q, out_valid_d;
   logic [127:0]      rk_w;
   logic [127:0]      round_out_w;

   assign rk_w        = round_key(key_q, round_q);
   assign round_out_w = aes_round(data_q, rk_w, round_q == NR4);

   // NOTE: every variable gets its hold value before the case so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      data_d      = data_q;
      key_d       = key_q;
      ct_d        = ct_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               key_d   = bus.key;
               data_d  = bus.plaintext ^ bus.key[KW-1 -: 128];
               round_d = 4'd1;
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (round_q == NR4) begin
               ct_d        = round_out_w;
               out_valid_d = 1'b1;
               round_d     = 4'd0;
               state_d     = DONE;
            end else begin
               data_d  = round_out_w;
               round_d = round_q + 4'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the key and state registers are datapath, but they are reset
   // anyway so an aborted block leaves nothing behind.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         round_q     <= 4'd0;
         data_q      <= '0;
         key_q       <= '0;
         ct_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         data_q      <= data_d;
         key_q       <= key_d;
         ct_q        <= ct_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready   = (state_q == IDLE) && !reset;
   assign bus.out_valid  = out_valid_q;
   assign bus.ciphertext = ct_q;
   assign bus.busy       = (state_q == ROUND);
endmodule

// File: tb/tb_aes_cipher_iterative.sv
// ---------------------------------------------------------------------------
// tb_aes_cipher_iterative
// Bench for aes_cipher_iterative with one instance each of AES-128/192/256.
// A byte-array AES model with a table S-box plus a transaction-level protocol
// model supply expected outputs; directed FIPS-197 vectors pin the model.
// ---------------------------------------------------------------------------
module tb_aes_cipher_iterative;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   aes_cipher_iterative_if #(.Nk(4)) if4 ();
   aes_cipher_iterative_if #(.Nk(6)) if6 ();
   aes_cipher_iterative_if #(.Nk(8)) if8 ();

   aes_cipher_iterative #(.Nk(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
   aes_cipher_iterative #(.Nk(6)) dut6 (.clk(clk), .reset(reset), .bus(if6));
   aes_cipher_iterative #(.Nk(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

   int tests  = 0;
   int failed = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference AES ----------------
   logic [2047:0] sbox_tab = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sb(input logic [7:0] x);
      return sbox_tab[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return (a[7]) ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
   endfunction

   // key is left-aligned in 256 bits; only the top nk words are used
   function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [255:0] key,
                                              input int nk);
      logic [7:0]   st [4][4];
      logic [7:0]   tmp [4][4];
      logic [31:0]  w [60];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [127:0] res;
      int           nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk == 8 && i % nk == 4) begin
            t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rd = 1; rd <= nr; rd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) tmp[r][c] = sb(st[r][(c+r)%4]);
         for (int c = 0; c < 4; c++) begin
            if (rd < nr) begin
               st[0][c] = xt(tmp[0][c]) ^ xt(tmp[1][c]) ^ tmp[1][c] ^ tmp[2][c] ^ tmp[3][c];
               st[1][c] = tmp[0][c] ^ xt(tmp[1][c]) ^ xt(tmp[2][c]) ^ tmp[2][c] ^ tmp[3][c];
               st[2][c] = tmp[0][c] ^ tmp[1][c] ^ xt(tmp[2][c]) ^ xt(tmp[3][c]) ^ tmp[3][c];
               st[3][c] = xt(tmp[0][c]) ^ tmp[0][c] ^ tmp[1][c] ^ tmp[2][c] ^ xt(tmp[3][c]);
            end else begin
               for (int r = 0; r < 4; r++) st[r][c] = tmp[r][c];
            end
            for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ w[4*rd+c][31-8*r -: 8];
         end
      end
      res = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) res[127-8*(4*c+r) -: 8] = st[r][c];
      return res;
   endfunction

   // ---------------- DUT access by index (0:Nk4, 1:Nk6, 2:Nk8) ----------------
   typedef struct packed {
      logic         in_valid, in_ready, out_valid, out_ready, busy;
      logic [127:0] pt, ct;
      logic [255:0] key;
   } snap_t;

   function automatic int nr_of(input int k);
      return 10 + 2*k;
   endfunction

   function automatic snap_t snap(input int k);
      snap_t s;
      s = '0;
      case (k)
         0: s = '{if4.in_valid, if4.in_ready, if4.out_valid, if4.out_ready, if4.busy,
                  if4.plaintext, if4.ciphertext, {if4.key, 128'h0}};
         1: s = '{if6.in_valid, if6.in_ready, if6.out_valid, if6.out_ready, if6.busy,
                  if6.plaintext, if6.ciphertext, {if6.key, 64'h0}};
         default: s = '{if8.in_valid, if8.in_ready, if8.out_valid, if8.out_ready, if8.busy,
                  if8.plaintext, if8.ciphertext, if8.key};
      endcase
      return s;
   endfunction

   task automatic drive(input int k, input logic v, input logic [127:0] pt, input logic [255:0] key);
      case (k)
         0: begin if4.in_valid = v; if4.plaintext = pt; if4.key = key[255 -: 128]; end
         1: begin if6.in_valid = v; if6.plaintext = pt; if6.key = key[255 -: 192]; end
         default: begin if8.in_valid = v; if8.plaintext = pt; if8.key = key; end
      endcase
   endtask

   task automatic set_ordy(input int k, input logic v);
      case (k)
         0: if4.out_ready = v;
         1: if6.out_ready = v;
         default: if8.out_ready = v;
      endcase
   endtask

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- transaction-level protocol model ----------------
   typedef enum {M_IDLE, M_RUN, M_DONE} mph_e;
   mph_e         ph   [3] = '{M_IDLE, M_IDLE, M_IDLE};
   int           cnt  [3] = '{0, 0, 0};
   logic [127:0] pend [3] = '{default: '0};
   logic [127:0] mct  [3] = '{default: '0};

   initial begin : model_proc
      snap_t s;
      forever begin
         @(posedge clk or posedge reset);
         for (int k = 0; k < 3; k++) begin
            if (reset) begin
               ph[k]  <= M_IDLE;
               cnt[k] <= 0;
               mct[k] <= '0;
            end else begin
               s = snap(k);
               case (ph[k])
                  M_IDLE: if (s.in_valid) begin
                     pend[k] <= aes_model(s.pt, s.key, 4 + 2*k);
                     cnt[k]  <= nr_of(k);
                     ph[k]   <= M_RUN;
                  end
                  M_RUN: begin
                     if (cnt[k] == 1) begin
                        ph[k]  <= M_DONE;
                        mct[k] <= pend[k];
                     end
                     cnt[k] <= cnt[k] - 1;
                  end
                  default: if (s.out_ready) ph[k] <= M_IDLE;
               endcase
            end
         end
      end
   end

   initial begin : compare_proc
      snap_t s;
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
               s = snap(k);
               check($sformatf("cyc.nk%0d.in_ready", 4+2*k), s.in_ready, (ph[k] == M_IDLE) && !reset);
               check($sformatf("cyc.nk%0d.out_valid", 4+2*k), s.out_valid, ph[k] == M_DONE);
               check($sformatf("cyc.nk%0d.busy", 4+2*k), s.busy, ph[k] == M_RUN);
               check($sformatf("cyc.nk%0d.ct", 4+2*k), s.ct, mct[k]);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [255:0] K2   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] CT3  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT4  = 128'h8ea2b7ca516745bfeafc49904b496089;

   // accept one block, check latency / busy length / result, then hand it off
   task automatic run_vec(input int k, input string tag, input logic [127:0] pt,
                          input logic [255:0] key, input logic [127:0] exp_ct);
      int    cyc, busy_n;
      snap_t s;
      set_ordy(k, 1'b1);
      @(posedge clk); #1 drive(k, 1'b1, pt, key);
      @(posedge clk); #1 drive(k, 1'b0, rnd256(), rnd256());
      cyc    = 0;
      s      = snap(k);
      busy_n = s.busy ? 1 : 0;
      while (!s.out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         s = snap(k);
         if (s.busy) busy_n++;
      end
      check({tag, ".latency"}, cyc, nr_of(k));
      check({tag, ".busy_cycles"}, busy_n, nr_of(k));
      check({tag, ".ct"}, s.ct, exp_ct);
      @(posedge clk); #1;
      s = snap(k);
      check({tag, ".in_ready_after"}, s.in_ready, 1'b1);
      check({tag, ".out_valid_after"}, s.out_valid, 1'b0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      snap_t        s;
      int           cyc, acc, nout;
      int           acc_t [2];
      logic [127:0] got [2];

      for (int k = 0; k < 3; k++) begin
         drive(k, 1'b0, '0, '0);
         set_ordy(k, 1'b0);
      end

      // reset state
      #1 reset = 1'b1;
      #1 cmp_en = 1'b1;
      #1 s = snap(0);
      check("rst.out_valid", s.out_valid, 1'b0);
      check("rst.busy", s.busy, 1'b0);
      check("rst.ct", s.ct, 128'h0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1 s = snap(0);
      check("rst.in_ready_after_release", s.in_ready, 1'b1);

      // pin the reference model to the published vectors
      check("model.aes128", aes_model(PT0, K128, 4), CT1);
      check("model.aes128b", aes_model(PT2, K2, 4), CT2);
      check("model.aes192", aes_model(PT0, K192, 6), CT3);
      check("model.aes256", aes_model(PT0, K256, 8), CT4);

      run_vec(0, "aes128", PT0, K128, CT1);
      run_vec(0, "aes128b", PT2, K2, CT2);
      run_vec(1, "aes192", PT0, K192, CT3);
      run_vec(2, "aes256", PT0, K256, CT4);

      // backpressure: result held while inputs churn
      set_ordy(0, 1'b0);
      @(posedge clk); #1 drive(0, 1'b1, PT0, K128);
      @(posedge clk); #1 drive(0, 1'b0, rnd256(), rnd256());
      cyc = 0;
      s   = snap(0);
      while (!s.out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         drive(0, cyc[0], rnd256(), rnd256());
         s = snap(0);
      end
      check("bp.latency", cyc, 10);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 drive(0, (i % 2) == 0, rnd256(), rnd256());
         @(negedge clk);
         s = snap(0);
         check("bp.out_valid_held", s.out_valid, 1'b1);
         check("bp.ct_held", s.ct, CT1);
         check("bp.in_ready_low", s.in_ready, 1'b0);
      end
      @(posedge clk); #1 drive(0, 1'b0, rnd256(), rnd256());
      set_ordy(0, 1'b1);
      @(posedge clk); #1 s = snap(0);
      check("bp.out_valid_cleared", s.out_valid, 1'b0);
      check("bp.in_ready_back", s.in_ready, 1'b1);
      check("bp.ct_kept_in_idle", s.ct, CT1);

      // reset during round 5
      @(posedge clk); #1 drive(0, 1'b1, PT2, K2);
      @(posedge clk); #1 drive(0, 1'b0, rnd256(), rnd256());
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1 s = snap(0);
      check("midrst.out_valid", s.out_valid, 1'b0);
      check("midrst.busy", s.busy, 1'b0);
      check("midrst.ct", s.ct, 128'h0);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 s = snap(0);
      check("midrst.in_ready_after", s.in_ready, 1'b1);
      run_vec(0, "midrst.next", PT0, K128, CT1);

      // back-to-back with in_valid held and out_ready tied high
      set_ordy(0, 1'b1);
      @(posedge clk); #1 drive(0, 1'b1, PT0, K128);
      acc = 0; nout = 0; cyc = 0;
      acc_t = '{0, 0};
      got   = '{default: '0};
      while (nout < 2 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         s = snap(0);
         if (s.in_valid && s.in_ready) begin
            if (acc < 2) acc_t[acc] = cyc;
            acc++;
         end
         if (s.out_valid) begin
            if (nout < 2) got[nout] = s.ct;
            nout++;
         end
         @(posedge clk); #1;
         if (acc == 1) drive(0, 1'b1, PT2, K2);
         else if (acc >= 2) drive(0, 1'b0, rnd256(), rnd256());
      end
      check("b2b.outputs", nout, 2);
      check("b2b.accepts", acc, 2);
      check("b2b.spacing", acc_t[1] - acc_t[0], 12);
      check("b2b.ct0", got[0], CT1);
      check("b2b.ct1", got[1], CT2);

      repeat (3) @(posedge clk);
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/aes_cipher_iterative.md
Name: aes_cipher_iterative

Overview:
- Sequential AES forward cipher (encryption) per FIPS-197. Counterpart of the combinational inverse cipher already in the codebase.
- Computes one round per clock on a single 128-bit state register, with valid/ready handshakes on input and output.
- Sits between the block-source interface and the ciphertext sink.
- Round functions and key schedule are the codebase's existing forward blocks: KeyExpansion, SubBytes, ShiftRows, MixColumns, AddRoundKey.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).
- Nr, Nk+6, round count; derived, never overridden.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  plaintext and key present.
- in_ready  output  1  block can accept a new plaintext.
- plaintext  input  128  [127:120] = byte 0 (s0,0), column-major order.
- key  input  Nk*32  cipher key; [Nk*32-1 -: 32] = w0.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  sink accepts ciphertext.
- ciphertext  output  128  result, same byte order as plaintext.
- busy  output  1  high in ROUND state.

Behaviour:
- Reset (async, immediate): FSM=IDLE, round counter=0, state reg=0, key reg=0, ciphertext=0, out_valid=0, busy=0. in_ready=1 once reset deasserts.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge T:
    - latch key into key reg;
    - state <= plaintext ^ key[Nk*32-1 -: 128] (round 0, computed from the input key directly);
    - round <= 1; go to ROUND.
  - ROUND: in_ready=0, busy=1. Each edge applies round r: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey(w[4r..4r+3]).
    - Round keys come from KeyExpansion driven by the latched key reg.
    - When r=Nr: MixColumns is skipped; the result goes into the ciphertext reg; out_valid <= 1; go to DONE. Otherwise round <= r+1.
  - DONE: out_valid=1, in_ready=0, busy=0. On out_valid&&out_ready: out_valid <= 0; go to IDLE.
- Latency: accept at edge T -> out_valid high after edge T+Nr (10/12/14 cycles).
- Minimum accept-to-accept spacing is Nr+2 cycles; no overlap of blocks.
- ciphertext is stable from out_valid rise until the handshake completes. It keeps its last value in IDLE and is only cleared by reset.
- in_valid outside IDLE is ignored and has no effect on the block in flight.
- key and plaintext may change freely after accept; the result depends only on the values sampled at accept.
- Round counter width is 4 bits; it never exceeds Nr.
- Round-key selection has no wrap-around: index 4r+3 <= 4Nr+3, within the (Nr+1)*4-word schedule.
- Reset asserted mid-ROUND or in DONE: computation aborts, every output goes to its reset value, nothing is emitted. The next accepted block is computed correctly.
- out_ready in IDLE or ROUND has no effect.
- Illegal Nk (anything other than 4/6/8) is an elaboration error via a generate-time check.

Test Plan:
- AES-128, Nk=4: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 10 cycles after accept; busy high for 10 cycles.
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32.
- AES-192/AES-256, pt 00112233445566778899aabbccddeeff:
  - Nk=6, key 000102...1617 -> dda97ca4864cdfe06eaf70a0ec0d7191 at 12 cycles;
  - Nk=8, key 000102...1e1f -> 8ea2b7ca516745bfeafc49904b496089 at 14 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, toggle in_valid and change key/plaintext throughout.
  - Required: out_valid and ciphertext stable, in_ready=0.
  - After out_ready=1: one handshake, then in_ready=1 the next cycle; the first result is unaffected by the changed inputs.
- Reset mid-operation: assert reset during round 5.
  - Required: out_valid=0, busy=0, ciphertext=0 immediately (async).
  - After release: in_ready=1; the next FIPS vector completes with the correct ciphertext.
- Back-to-back: two blocks with in_valid held high and out_ready tied high.
  - Required: two correct ciphertexts, with the second accept exactly Nr+2 cycles after the first.
